// File: rtl/wb_evict_buffer_if.sv
// Eviction, lookup and memory-write signals between the cache,
// the eviction buffer and main memory.
interface wb_evict_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  evict_valid;
    logic                  evict_ready;
    logic [ADDR_WIDTH-1:0] evict_addr;
    logic [DATA_WIDTH-1:0] evict_data;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_hit;
    logic [DATA_WIDTH-1:0] lookup_data;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;

    modport master (
        output evict_valid, evict_addr, evict_data,
        output lookup_addr, mem_ack,
        input  evict_ready, lookup_hit, lookup_data,
        input  mem_req, mem_addr, mem_wdata
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data,
        input  lookup_addr, mem_ack,
        output evict_ready, lookup_hit, lookup_data,
        output mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wb_evict_buffer.sv
// Write-back eviction FIFO: coalesces repeat evictions, forwards
// buffered data to miss lookups and drains to memory via req/ack.
module wb_evict_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_evict_buffer_if.slave       bus,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ADDR_WIDTH - 2;

    typedef enum logic {IDLE, REQ} state_t;

    logic [DEPTH-1:0]      valid;
    logic [TW-1:0]         tags [DEPTH];
    logic [DATA_WIDTH-1:0] data [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    state_t                state;
    logic                  flush_seen;

    logic [TW-1:0]         evict_tag;
    logic [TW-1:0]         lookup_tag;
    logic                  push;
    logic                  pop;
    logic                  co_hit;
    logic [PW-1:0]         co_idx;
    logic                  alloc;
    logic                  merge;
    logic [CW-1:0]         cnt_next;
    logic [PW-1:0]         ld_idx;
    logic [TW-1:0]         ld_tag;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  unused;

    assign evict_tag  = bus.evict_addr[ADDR_WIDTH-1:2];
    assign lookup_tag = bus.lookup_addr[ADDR_WIDTH-1:2];
    assign unused     = ^{bus.evict_addr[1:0], bus.lookup_addr[1:0]};

    assign bus.evict_ready = (count < CW'(DEPTH)) && !flush;
    assign push  = bus.evict_valid && bus.evict_ready;
    assign pop   = (state == REQ) && bus.mem_ack;
    assign alloc = push && !co_hit;
    assign merge = push && co_hit;
    assign cnt_next = count - CW'(pop) + CW'(alloc);

    // The in-flight head is excluded so an issued write is never altered.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tags[i] == evict_tag &&
                !(state == REQ && PW'(i) == head)) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[head + PW'(k)] &&
                tags[head + PW'(k)] == lookup_tag) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = data[head + PW'(k)];
            end
        end
    end

    // Next write source, bypassing a same-cycle push into that entry.
    always_comb begin
        ld_idx  = (state == REQ) ? head + PW'(1) : head;
        ld_tag  = tags[ld_idx];
        ld_data = data[ld_idx];
        if (alloc && tail == ld_idx) begin
            ld_tag  = evict_tag;
            ld_data = bus.evict_data;
        end else if (merge && co_idx == ld_idx) begin
            ld_data = bus.evict_data;
        end
    end

    assign flush_done = flush && !flush_seen &&
                        count == '0 && state == IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            flush_seen    <= 1'b0;
        end else begin
            if (alloc) begin
                valid[tail] <= 1'b1;
                tags[tail]  <= evict_tag;
                data[tail]  <= bus.evict_data;
                tail        <= tail + PW'(1);
            end
            if (merge) begin
                data[co_idx] <= bus.evict_data;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count      <= cnt_next;
            flush_seen <= flush && (flush_seen || flush_done);
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state         <= REQ;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= {ld_tag, 2'b00};
                        bus.mem_wdata <= ld_data;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (cnt_next != '0) begin
                            bus.mem_addr  <= {ld_tag, 2'b00};
                            bus.mem_wdata <= ld_data;
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_evict_buffer.sv
// Scoreboard bench for wb_evict_buffer: expected memory writes are
// queued at issue time and checked by a negedge monitor.
module tb_wb_evict_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       flush_done;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t expq[$];
    wr_t e;

    wb_evict_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_evict_buffer #(
        .DEPTH(4),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .flush(flush),
        .flush_done(flush_done),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && bus.mem_req && bus.mem_ack) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%h data=%h, required none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = expq.pop_front();
                if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
                    fails++;
                    $display("FAIL mem_write got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.evict_valid = 1'b1;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        step(1);
        bus.evict_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        expq.push_back(w);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((bus.mem_req || count != 3'd0) && n < 60) begin
            step(1);
            n++;
        end
        check(nm, 32'(n < 60), 32'd1);
    endtask

    initial begin
        int pulses;
        reset           = 1'b1;
        flush           = 1'b0;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.lookup_addr = '0;
        bus.mem_ack     = 1'b0;
        step(2);
        reset = 1'b0;

        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_evict_ready", 32'(bus.evict_ready), 32'd1);
        check("rst_lookup_hit", 32'(bus.lookup_hit), 32'd0);

        // single eviction
        bus.mem_ack = 1'b1;
        expect_wr(32'h4, 32'hCAFEBABE);
        push(32'h4, 32'hCAFEBABE);
        check("single_count1", 32'(count), 32'd1);
        check("single_req_early", 32'(bus.mem_req), 32'd0);
        step(1);
        check("single_req", 32'(bus.mem_req), 32'd1);
        check("single_addr", bus.mem_addr, 32'h4);
        check("single_wdata", bus.mem_wdata, 32'hCAFEBABE);
        step(1);
        check("single_count0", 32'(count), 32'd0);
        check("single_req_off", 32'(bus.mem_req), 32'd0);

        // full buffer, rejection, then wrap-around
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(bus.evict_ready), 32'd0);
        push(32'h110, 32'hBAD0BAD0);
        check("full_reject", 32'(count), 32'd4);
        bus.mem_ack = 1'b1;
        drain("full_drain");
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            push(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        end
        drain("wrap_drain");

        // coalescing behind an in-flight blocker
        bus.mem_ack = 1'b0;
        expect_wr(32'h30, 32'h33333333);
        expect_wr(32'h10, 32'h22222222);
        expect_wr(32'h20, 32'h20202020);
        push(32'h30, 32'h33333333);
        step(1);
        push(32'h10, 32'h11111111);
        push(32'h20, 32'h20202020);
        push(32'h10, 32'h22222222);
        check("coal_count", 32'(count), 32'd3);
        bus.lookup_addr = 32'h10;
        #1;
        check("coal_lookup", bus.lookup_data, 32'h22222222);
        bus.mem_ack = 1'b1;
        drain("coal_drain");

        // forwarding with the head in flight
        bus.mem_ack = 1'b0;
        expect_wr(32'h14, 32'hDEADBEEF);
        expect_wr(32'h14, 32'hBEEF0001);
        push(32'h14, 32'hDEADBEEF);
        step(1);
        check("fwd_inflight", bus.mem_addr, 32'h14);
        push(32'h14, 32'hBEEF0001);
        check("fwd_count", 32'(count), 32'd2);
        bus.lookup_addr = 32'h14;
        #1;
        check("fwd_hit", 32'(bus.lookup_hit), 32'd1);
        check("fwd_data", bus.lookup_data, 32'hBEEF0001);
        bus.lookup_addr = 32'h17;
        #1;
        check("fwd_lowbits_hit", 32'(bus.lookup_hit), 32'd1);
        bus.lookup_addr = 32'h18;
        #1;
        check("fwd_miss_hit", 32'(bus.lookup_hit), 32'd0);
        check("fwd_miss_data", bus.lookup_data, 32'd0);
        check("fwd_head_held", bus.mem_wdata, 32'hDEADBEEF);
        bus.mem_ack = 1'b1;
        drain("fwd_drain");

        // flush
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_wr(32'h40 + 32'(4 * i), 32'hF000_0000 + 32'(i));
            push(32'h40 + 32'(4 * i), 32'hF000_0000 + 32'(i));
        end
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(bus.evict_ready), 32'd0);
        push(32'h4C, 32'hBAD1BAD1);
        check("flush_block", 32'(count), 32'd3);
        bus.mem_ack = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (flush_done) begin
                pulses++;
                check("flush_done_count", 32'(count), 32'd0);
            end
        end
        check("flush_pulses", 32'(pulses), 32'd1);
        flush = 1'b0;
        step(1);

        // reset during an outstanding write
        bus.mem_ack = 1'b0;
        push(32'h50, 32'h55555555);
        step(1);
        check("mid_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.lookup_addr = 32'h50;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_hit", 32'(bus.lookup_hit), 32'd0);
        bus.mem_ack = 1'b1;
        expect_wr(32'h60, 32'h66666666);
        push(32'h60, 32'h66666666);
        drain("post_rst_drain");

        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
